// File: rtl/serv_mtimer_if.sv
// serv_mtimer_if: 32-bit Wishbone responder port of the machine timer.
// The master drives the request fields; the slave (timer) returns read data
// and a single-cycle acknowledge.
interface serv_mtimer_if;
  logic        i_wb_cyc;
  logic        i_wb_we;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/serv_mtimer.sv
// serv_mtimer: RISC-V machine timer (mtime / mtimecmp) on the SERV Wishbone
// data bus. A prescaled free-running mtime is compared against mtimecmp to
// drive a registered, level-sensitive o_mtip.
//
// Build option: define SERV_MTIMER_64BIT_EN for 64-bit mtime/mtimecmp with
// the upper halves at word addresses 1 and 3. Without it both registers are
// 32 bits and addresses 1/3 read as zero, ignore writes and are still acked.
module serv_mtimer #(
  parameter int DIV            = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic         i_clk,
  input  logic         i_rst,
  serv_mtimer_if.slave wb,
  output logic         o_mtip
);

`ifdef SERV_MTIMER_64BIT_EN
  localparam int W = 64;
`else
  localparam int W = 32;
`endif

  // "NONE" keeps the datapath unreset; the bus FSM and ack always reset.
  localparam bit RST_ALL = (RESET_STRATEGY != "NONE");

  typedef enum logic {IDLE, ACK} state_t;

  state_t       state;
  logic         ack_r;
  logic [31:0]  rdt_r;
  logic [W-1:0] mtime;
  logic [W-1:0] mtimecmp;
  logic [W-1:0] mtime_inc;
  logic [W-1:0] mtime_nxt;
  logic [W-1:0] cmp_nxt;
  logic [31:0]  rd_val;
  logic         tick;
  logic         req;
  logic         wr_en;
  logic         rd_en;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    end
    return r;
  endfunction

  generate
    if (DIV == 1) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int PW = $clog2(DIV);
      logic [PW-1:0] pre;

      assign tick = (pre == PW'(DIV - 1));

      // Prescaler: counts 0..DIV-1 and wraps on tick.
      always_ff @(posedge i_clk) begin
        if (RST_ALL && i_rst) pre <= '0;
        else if (tick)        pre <= '0;
        else                  pre <= pre + PW'(1);
      end
    end
  endgenerate

  // Requests are only taken in IDLE, so a held cyc is acked every other cycle.
  assign req   = (state == IDLE) && wb.i_wb_cyc && !i_rst;
  assign wr_en = req && wb.i_wb_we;
  assign rd_en = req && !wb.i_wb_we;

  // Read mux sees the registers before any increment of this cycle.
  always_comb begin
    rd_val = '0;
    case (wb.i_wb_adr)
      2'd0:    rd_val = mtime[31:0];
      2'd2:    rd_val = mtimecmp[31:0];
`ifdef SERV_MTIMER_64BIT_EN
      2'd1:    rd_val = mtime[63:32];
      2'd3:    rd_val = mtimecmp[63:32];
`endif
      default: rd_val = '0;
    endcase
  end

  // Next register values: a written mtime half merges the written bytes into
  // the already-incremented value, so the other half still sees the carry.
  always_comb begin
    mtime_inc = mtime + W'(tick);
    mtime_nxt = mtime_inc;
    cmp_nxt   = mtimecmp;
    if (wr_en) begin
      case (wb.i_wb_adr)
        2'd0:    mtime_nxt[31:0] = byte_merge(mtime_inc[31:0], wb.i_wb_dat, wb.i_wb_sel);
        2'd2:    cmp_nxt[31:0]   = byte_merge(mtimecmp[31:0], wb.i_wb_dat, wb.i_wb_sel);
`ifdef SERV_MTIMER_64BIT_EN
        2'd1:    mtime_nxt[63:32] = byte_merge(mtime_inc[63:32], wb.i_wb_dat, wb.i_wb_sel);
        2'd3:    cmp_nxt[63:32]   = byte_merge(mtimecmp[63:32], wb.i_wb_dat, wb.i_wb_sel);
`endif
        default: ;
      endcase
    end
  end

  // Bus FSM with registered ack; reset drops any pending ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ack_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wb.i_wb_cyc) begin
            state <= ACK;
            ack_r <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack_r <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack_r <= 1'b0;
        end
      endcase
    end
  end

  // Timer registers, read-data capture and the one-cycle-late compare.
  always_ff @(posedge i_clk) begin
    if (RST_ALL && i_rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      o_mtip   <= 1'b0;
      rdt_r    <= '0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      o_mtip   <= (mtime >= mtimecmp);
      if (rd_en) rdt_r <= rd_val;
    end
  end

  assign wb.o_wb_ack = ack_r;
  assign wb.o_wb_rdt = rdt_r;

endmodule

// File: tb/tb_serv_mtimer.sv
// tb_serv_mtimer: directed bench for serv_mtimer. Two instances (DIV=1 and
// DIV=4) receive identical bus traffic; a behavioural model of each is
// checked every cycle, plus hand-computed literal expectations.
module tb_serv_mtimer;

`ifdef SERV_MTIMER_64BIT_EN
  localparam int W = 64;
`else
  localparam int W = 32;
`endif
  localparam logic [63:0] MASK = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                           : 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        mtip1;
  logic        mtip4;
  bit          chk_on = 1'b0;
  int          total = 0;
  int          bad = 0;

  serv_mtimer_if bus1 ();
  serv_mtimer_if bus4 ();

  assign bus1.i_wb_cyc = cyc;
  assign bus1.i_wb_we  = we;
  assign bus1.i_wb_adr = adr;
  assign bus1.i_wb_dat = dat;
  assign bus1.i_wb_sel = sel;
  assign bus4.i_wb_cyc = cyc;
  assign bus4.i_wb_we  = we;
  assign bus4.i_wb_adr = adr;
  assign bus4.i_wb_dat = dat;
  assign bus4.i_wb_sel = sel;

  serv_mtimer #(.DIV(1)) dut1 (.i_clk(clk), .i_rst(rst), .wb(bus1.slave), .o_mtip(mtip1));
  serv_mtimer #(.DIV(4)) dut4 (.i_clk(clk), .i_rst(rst), .wb(bus4.slave), .o_mtip(mtip4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_mtip [2];
  logic        m_ack  [2];
  logic [31:0] m_rdt  [2];
  int          m_cnt  [2];

  function automatic logic [31:0] mrg(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [63:0] t, input logic [63:0] c, input logic [1:0] a);
    case (a)
      2'd0:    return t[31:0];
      2'd1:    return (W == 64) ? t[63:32] : 32'd0;
      2'd2:    return c[31:0];
      default: return (W == 64) ? c[63:32] : 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int          dv;
    logic        tk;
    logic        acc;
    logic        nmt;
    logic [63:0] nt;
    logic [63:0] nc;
    for (int k = 0; k < 2; k++) begin
      dv = (k == 0) ? 1 : 4;
      if (rst) begin
        m_time[k] = 64'd0;
        m_cmp[k]  = MASK;
        m_mtip[k] = 1'b0;
        m_ack[k]  = 1'b0;
        m_rdt[k]  = 32'd0;
        m_cnt[k]  = 0;
      end else begin
        tk  = ((m_cnt[k] % dv) == dv - 1);
        m_cnt[k]++;
        nmt = (m_time[k] >= m_cmp[k]);
        acc = !m_ack[k] && cyc;
        nt  = (m_time[k] + (tk ? 64'd1 : 64'd0)) & MASK;
        nc  = m_cmp[k];
        if (acc && !we) m_rdt[k] = mread(m_time[k], m_cmp[k], adr);
        if (acc && we) begin
          case (adr)
            2'd0: nt[31:0] = mrg(nt[31:0], dat, sel);
            2'd1: if (W == 64) nt[63:32] = mrg(nt[63:32], dat, sel);
            2'd2: nc[31:0] = mrg(nc[31:0], dat, sel);
            default: if (W == 64) nc[63:32] = mrg(nc[63:32], dat, sel);
          endcase
        end
        m_time[k] = nt;
        m_cmp[k]  = nc;
        m_mtip[k] = nmt;
        m_ack[k]  = acc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack1", bus1.o_wb_ack, m_ack[0]);
      chk("mtip1", mtip1, m_mtip[0]);
      if (m_ack[0]) chk("rdt1", bus1.o_wb_rdt, m_rdt[0]);
      chk("ack4", bus4.o_wb_ack, m_ack[1]);
      chk("mtip4", mtip4, m_mtip[1]);
      if (m_ack[1]) chk("rdt4", bus4.o_wb_rdt, m_rdt[1]);
    end
  end

  // One transfer; called just after a negedge, returns after the ACK cycle.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r1,
                      output logic [31:0] r4, output logic mt1);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(negedge clk);
    chk("xfer_ack", bus1.o_wb_ack, 1'b1);
    r1  = bus1.o_wb_rdt;
    r4  = bus4.o_wb_rdt;
    mt1 = mtip1;
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] x1, x4;
    logic        m;
    xfer(1'b1, a, d, s, x1, x4, m);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r1, output logic [31:0] r4);
    logic m;
    xfer(1'b0, a, 32'd0, 4'hF, r1, r4, m);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r1, r4;
    logic        mt;
    int          acks;

    rst = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_mtip", mtip1, 1'b0);
    rd(2'd0, r1, r4);
    chk("rst_mtime1", r1, 32'h0);
    chk("rst_mtime4", r4, 32'h0);
    rd(2'd2, r1, r4);
    chk("rst_cmp", r1, 32'hFFFF_FFFF);

    // Byte enables over the reset value of mtimecmp
    wr(2'd2, 32'hAABB_CCDD, 4'b0101);
    rd(2'd2, r1, r4);
    chk("bytesel1", r1, 32'hFFBB_FFDD);
    chk("bytesel4", r4, 32'hFFBB_FFDD);

    // Prescaler: 39 edges elapse between write and read sample
    wr(2'd0, 32'd0, 4'hF);
    repeat (38) @(negedge clk);
    rd(2'd0, r1, r4);
    chk("presc1", r1, 32'd39);
    total++;
    if (r4 < 32'd9 || r4 > 32'd11) begin
      bad++;
      $display("FAIL presc4: got %0d want 9..11", r4);
    end

    // Interrupt rise 11 cycles after the mtime write edge
`ifdef SERV_MTIMER_64BIT_EN
    wr(2'd3, 32'd0, 4'hF);
    wr(2'd1, 32'd0, 4'hF);
`endif
    wr(2'd2, 32'd100, 4'hF);
    wr(2'd0, 32'd90, 4'hF);
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (i == 10) chk("mtip_before", mtip1, 1'b0);
      if (i == 11) chk("mtip_rise", mtip1, 1'b1);
    end

    // Raising mtimecmp drops o_mtip one cycle after the write edge
    xfer(1'b1, 2'd2, 32'd1000, 4'hF, r1, r4, mt);
    chk("mtip_hold", mt, 1'b1);
    chk("mtip_fall", mtip1, 1'b0);

    // Carry / wrap of the low word
    wr(2'd0, 32'hFFFF_FFFE, 4'hF);
    @(negedge clk);
    rd(2'd0, r1, r4);
    chk("carry_lo", r1, 32'h0);
    rd(2'd1, r1, r4);
    chk("carry_hi", r1, (W == 64) ? 32'd1 : 32'd0);

    // Partial write on a tick merges into the incremented value
    wr(2'd0, 32'h0000_01FE, 4'hF);
    wr(2'd0, 32'h0000_0080, 4'b0001);
    rd(2'd0, r1, r4);
    chk("merge_tick", r1, 32'h0000_0281);

    // Upper word of mtime: real register or read-as-zero
    wr(2'd1, 32'h1234_5678, 4'hF);
    rd(2'd1, r1, r4);
    chk("hi_word", r1, (W == 64) ? 32'h1234_5678 : 32'd0);

    // Held cycle: ack on alternate cycles
    cyc = 1'b1; we = 1'b0; adr = 2'd2; acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.o_wb_ack) acks++;
      chk("held_ack", bus1.o_wb_ack, (i % 2) == 0);
    end
    cyc = 1'b0;
    chk("held_count", acks, 3);

    // Reset during ACK drops the ack
    cyc = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", bus1.o_wb_ack, 1'b1);
    cyc = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ack_drop", bus1.o_wb_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_mtip", mtip1, 1'b0);
    rd(2'd0, r1, r4);
    chk("rst2_mtime", r1, 32'h0);
    rd(2'd2, r1, r4);
    chk("rst2_cmp", r1, 32'hFFFF_FFFF);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
